// File: rtl/vga_renderer.sv
// VGA 640x480@60 back-end: pixel timing from the 50 MHz clock, world sampling,
// procedural 32x32 tile drawing and one aligned output register stage.
module vga_renderer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       clock_50,
    input  logic       reset,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    input  logic [3:0] sprite,
    input  logic [1:0] robot_cursor_flags,
    input  logic [4:0] robot_type,
    output logic [3:0] vga_r,
    output logic [3:0] vga_g,
    output logic [3:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n,
    output logic       vga_clk,
    output logic       frame_start
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef enum logic [1:0] {
        DIR_NORTH = 2'd0,
        DIR_SOUTH = 2'd1,
        DIR_EAST  = 2'd2,
        DIR_WEST  = 2'd3
    } dir_t;

    logic        tick_r;
    logic [9:0]  h_r;
    logic [9:0]  v_r;
    logic [3:0]  s1_sprite_r;
    logic [1:0]  s1_flags_r;
    logic [4:0]  s1_type_r;
    logic [9:0]  s1_h_r;
    logic [9:0]  s1_v_r;
    logic [4:0]  s1_lx_r;
    logic [4:0]  s1_ly_r;
    logic [11:0] rgb_r;
    logic        hs_r;
    logic        vs_r;
    logic        blank_n_r;
    logic        frame_start_r;

    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        visible_s;
    logic [11:0] colour_s;
    logic        hs_s;
    logic        vs_s;

    // Tile artwork for one pixel; cursor ring beats robot, robot beats the tile.
    function automatic logic [11:0] tile_colour(
        input logic [3:0] spr,
        input logic [1:0] flags,
        input logic [4:0] rtype,
        input logic [4:0] lx,
        input logic [4:0] ly
    );
        logic        cursor;
        logic        body;
        logic        strip;
        logic        square;
        logic        mortar;
        logic [3:0]  mortar_col;
        logic [11:0] c;
        dir_t        dir;
        cursor = (lx[4:1] == 4'h0) || (lx[4:1] == 4'hF) ||
                 (ly[4:1] == 4'h0) || (ly[4:1] == 4'hF);
        body   = (lx >= 5'd4) && (lx <= 5'd27) && (ly >= 5'd4) && (ly <= 5'd27);
        square = (lx >= 5'd8) && (lx <= 5'd23) && (ly >= 5'd8) && (ly <= 5'd23);
        mortar_col = ly[3] ? 4'd8 : 4'd0;
        mortar = (ly[2:0] == 3'd0) || (lx[3:0] == mortar_col);
        case (rtype)
            5'b00100: dir = DIR_SOUTH;
            5'b01000: dir = DIR_EAST;
            5'b10000: dir = DIR_WEST;
            default:  dir = DIR_NORTH;
        endcase
        // Strip bounds only need the outer limit; body already confines the rest.
        case (dir)
            DIR_NORTH: strip = (ly <= 5'd7);
            DIR_SOUTH: strip = (ly >= 5'd24);
            DIR_EAST:  strip = (lx >= 5'd24);
            DIR_WEST:  strip = (lx <= 5'd7);
            default:   strip = 1'b0;
        endcase
        if (flags[0] && cursor) begin
            c = 12'hFF0;
        end else if (flags[1] && body) begin
            c = strip ? 12'hFFF : 12'h00F;
        end else begin
            case (spr)
                4'd0:    c = mortar ? 12'h888 : 12'hC42;
                4'd1:    c = 12'h444;
                4'd3:    c = square ? 12'h0C0 : 12'h444;
                4'd4:    c = square ? 12'hCC0 : 12'h444;
                4'd5:    c = square ? 12'hF00 : 12'h444;
                4'd6:    c = 12'h000;
                default: c = 12'hF0F;
            endcase
        end
        return c;
    endfunction

    assign h_wrap_s = (h_r == H_LAST);
    assign v_wrap_s = (v_r == V_LAST);

    // Pixel-clock divider and raster counters.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            tick_r        <= 1'b0;
            h_r           <= 10'd0;
            v_r           <= 10'd0;
            frame_start_r <= 1'b0;
        end else begin
            tick_r        <= ~tick_r;
            frame_start_r <= tick_r && h_wrap_s && v_wrap_s;
            if (tick_r) begin
                if (h_wrap_s) begin
                    h_r <= 10'd0;
                    v_r <= v_wrap_s ? 10'd0 : v_r + 10'd1;
                end else begin
                    h_r <= h_r + 10'd1;
                end
            end
        end
    end

    // Stage 1: capture the world response on the second clock of the coordinate hold.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            s1_sprite_r <= 4'd0;
            s1_flags_r  <= 2'd0;
            s1_type_r   <= 5'd0;
            s1_h_r      <= 10'd0;
            s1_v_r      <= 10'd0;
            s1_lx_r     <= 5'd0;
            s1_ly_r     <= 5'd0;
        end else if (tick_r) begin
            s1_sprite_r <= sprite;
            s1_flags_r  <= robot_cursor_flags;
            s1_type_r   <= robot_type;
            s1_h_r      <= h_r;
            s1_v_r      <= v_r;
            s1_lx_r     <= h_r[4:0];
            s1_ly_r     <= v_r[4:0];
        end
    end

    // Colour and syncs derived from the same stage-1 coordinates to stay aligned.
    always_comb begin
        visible_s = (s1_h_r < H_VIS) && (s1_v_r < V_VIS);
        hs_s      = !((s1_h_r >= HS_FIRST) && (s1_h_r <= HS_LAST));
        vs_s      = !((s1_v_r >= VS_FIRST) && (s1_v_r <= VS_LAST));
        if (visible_s) begin
            colour_s = tile_colour(s1_sprite_r, s1_flags_r, s1_type_r, s1_lx_r, s1_ly_r);
        end else begin
            colour_s = 12'h000;
        end
    end

    // Stage 2: output register feeding the VGA pins.
    always_ff @(posedge clock_50 or posedge reset) begin
        if (reset) begin
            rgb_r     <= 12'h000;
            hs_r      <= 1'b1;
            vs_r      <= 1'b1;
            blank_n_r <= 1'b0;
        end else if (tick_r) begin
            rgb_r     <= colour_s;
            hs_r      <= hs_s;
            vs_r      <= vs_s;
            blank_n_r <= visible_s;
        end
    end

    assign pixel_x     = h_r;
    assign pixel_y     = v_r;
    assign vga_r       = rgb_r[11:8];
    assign vga_g       = rgb_r[7:4];
    assign vga_b       = rgb_r[3:0];
    assign vga_hs      = hs_r;
    assign vga_vs      = vs_r;
    assign vga_blank_n = blank_n_r;
    assign vga_clk     = tick_r;
    assign frame_start = frame_start_r;

endmodule
